cnn_layer1: RTL and testbench



---
 rtl/cnn_pkg.sv | 26 ++
 rtl/bin_conv3x3.sv | 15 +
 rtl/cnn_layer1.sv | 154 +++++++++++++++
 tb/tb_cnn_layer1.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and popcount helper for the binarized CNN layer 1.
package cnn_pkg;

  localparam int IMG_W   = 28;            // input image width/height
  localparam int CONV_W  = 26;            // valid 3x3 convolution output width
  localparam int POOL_W  = 13;            // pooled output width (CONV_W / 2)
  localparam int POOL_SZ = POOL_W * POOL_W;
  localparam int IMG_PIX = IMG_W * IMG_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of set bits in a 9-bit vector (0..9).
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/bin_conv3x3.sv
// One binary 3x3 convolution point: XNOR the window with the kernel, count the
// matches and compare against the threshold.
module bin_conv3x3
  import cnn_pkg::*;
#(
  parameter int THRESH = 5
) (
  input  logic [8:0] window,
  input  logic [8:0] kernel,
  output logic       bit_out
);

  assign bit_out = (popcount9(~(window ^ kernel)) >= 4'(THRESH));

endmodule

// File: rtl/cnn_layer1.sv
// Binarized CNN layer 1: load a 28x28 1-bit image from ROM, then stream one
// 2x2-max-pooled 3x3 binary convolution result per clock for every kernel.
//
// Output handshake: sign2 is a pure valid strobe with no ready. While sign2=1,
// res and addra carry one pooled result. Strobes are back-to-back for
// NUM_K*169 cycles and the consumer must accept every one.
module cnn_layer1
  import cnn_pkg::*;
#(
  parameter int                 NUM_K     = 32,
  parameter int                 THRESH    = 5,
  parameter logic [NUM_K*9-1:0] KERNELS   = '0,
  parameter string              INIT_FILE = "image.mem"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        sign,
  output logic        sign2,
  output logic        res,
  output logic [12:0] addra
);

  localparam logic [12:0] LAST_ADDR = 13'(NUM_K * POOL_SZ - 1);
  localparam logic [3:0]  POOL_LAST = 4'(POOL_W - 1);

  state_t      state;
  logic [9:0]  load_cnt;   // ROM address being issued during LOAD
  logic        rd_vld;     // rom_q holds a pixel to be written this cycle
  logic [9:0]  wr_addr;    // buffer address of the pixel in rom_q
  logic        rom_q;
  logic [IMG_PIX-1:0] pix_buf;

  logic [5:0]  k;
  logic [3:0]  pr;
  logic [3:0]  pc;
  logic [12:0] cnt;

  logic [8:0]  kern;
  logic [8:0]  win [4];
  logic [3:0]  conv;
  logic [9:0]  row_base;
  logic [9:0]  col_base;

  // Image ROM storage.
  logic rom [0:IMG_PIX-1];

  // Synchronous ROM read, one cycle latency.
  always_ff @(posedge clk) begin
    if (load_cnt < 10'(IMG_PIX)) begin
      rom_q <= rom[load_cnt];
    end
  end

  // Pixel buffer fill; data only, sequencing is carried by rd_vld.
  always_ff @(posedge clk) begin
    if (rd_vld) begin
      pix_buf[wr_addr] <= rom_q;
    end
  end

  // Select the kernel of the current output channel.
  always_comb begin
    kern = '0;
    for (int j = 0; j < NUM_K; j++) begin
      if (k == 6'(j)) begin
        kern = KERNELS[j*9 +: 9];
      end
    end
  end

  // Gather the four 3x3 windows of the current 2x2 pooling cell.
  always_comb begin
    row_base = 10'(pr) * 10'd56;   // 2*pr rows of 28 pixels
    col_base = 10'(pc) * 10'd2;
    for (int p = 0; p < 4; p++) begin
      win[p] = '0;
      for (int i = 0; i < 9; i++) begin
        win[p][i] = pix_buf[row_base + col_base +
                            10'(((p / 2) + (i / 3)) * IMG_W + (p % 2) + (i % 3))];
      end
    end
  end

  for (genvar p = 0; p < 4; p++) begin : g_conv
    bin_conv3x3 #(
      .THRESH(THRESH)
    ) u_conv (
      .window (win[p]),
      .kernel (kern),
      .bit_out(conv[p])
    );
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      rd_vld   <= 1'b0;
      wr_addr  <= '0;
      k        <= '0;
      pr       <= '0;
      pc       <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      sign2    <= 1'b0;
      res      <= 1'b0;
      addra    <= '0;
    end else begin
      case (state)
        LOAD: begin
          sign2    <= 1'b0;
          res      <= 1'b0;
          load_cnt <= load_cnt + 10'd1;
          rd_vld   <= (load_cnt < 10'(IMG_PIX));
          wr_addr  <= load_cnt;
          // Pixel 783 is being written on this edge: the buffer is complete.
          if (load_cnt == 10'(IMG_PIX)) begin
            sign  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sign2 <= 1'b1;
          res   <= |conv;
          addra <= cnt;
          cnt   <= cnt + 13'd1;
          if (pc == POOL_LAST) begin
            pc <= '0;
            if (pr == POOL_LAST) begin
              pr <= '0;
              k  <= k + 6'd1;
            end else begin
              pr <= pr + 4'd1;
            end
          end else begin
            pc <= pc + 4'd1;
          end
          if (cnt == LAST_ADDR) begin
            state <= DONE;
          end
        end
        DONE: begin
          sign2 <= 1'b0;
          res   <= 1'b0;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer1.sv
// Bench for cnn_layer1: loads images into the ROM, predicts every pooled result
// from the convolution/pooling rules and compares against the output stream.
module tb_cnn_layer1;

  localparam int          NUM_K   = 4;
  localparam int          THRESH  = 5;
  localparam logic [35:0] TB_KERN = {9'h155, 9'h0AA, 9'h1FF, 9'h001};
  localparam int          N_OUT   = NUM_K * 169;

  logic        clk;
  logic        rst_n;
  logic        sign;
  logic        sign2;
  logic        res;
  logic [12:0] addra;

  int n_checks;
  int n_pass;

  bit img [784];
  logic [13:0] exp_q [$];

  cnn_layer1 #(
    .NUM_K    (NUM_K),
    .THRESH   (THRESH),
    .KERNELS  (TB_KERN),
    .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sign (sign),
    .sign2(sign2),
    .res  (res),
    .addra(addra)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial rst_n = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: pooled result for every (k, pr, pc) in output order.
  task automatic build_expected();
    logic [35:0] kv;
    kv = TB_KERN;
    exp_q.delete();
    for (int k = 0; k < NUM_K; k++)
      for (int pr = 0; pr < 13; pr++)
        for (int pc = 0; pc < 13; pc++) begin
          bit b;
          b = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              int r, c, m;
              r = 2 * pr + dy;
              c = 2 * pc + dx;
              m = 0;
              for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                  if (img[(r + ky) * 28 + c + kx] == kv[9 * k + 3 * ky + kx]) m++;
              if (m >= THRESH) b = 1;
            end
          exp_q.push_back({13'(k * 169 + pr * 13 + pc), b});
        end
  endtask

  // Image generators: 0 zeros, 1 ones, 2 single pixel, 3 checkerboard, 4 random
  task automatic set_image(input int mode);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        case (mode)
          0: img[r * 28 + c] = 0;
          1: img[r * 28 + c] = 1;
          2: img[r * 28 + c] = (r == 0 && c == 0);
          3: img[r * 28 + c] = bit'((r + c) & 1);
          default: img[r * 28 + c] = bit'($urandom_range(0, 1));
        endcase
      end
  endtask

  // Driver: hold reset, check outputs every cycle, load ROM and expectations.
  task automatic reset_and_load(input int hold);
    rst_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("reset_outputs", {17'd0, sign, sign2, res, addra}, 32'd0);
    end
    for (int i = 0; i < 784; i++) dut.rom[i] = img[i];
    build_expected();
  endtask

  // Driver: release reset on a falling edge and follow the whole run.
  // abort_at >= 0 pulls reset once addra reaches that value.
  task automatic release_and_check(input int abort_at);
    int cyc;
    int n;
    rst_n = 1'b1;
    cyc = 0;
    while (!sign && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("sign_rise_cycle", cyc, 785);
    chk("sign2_low_at_sign", {31'd0, sign2}, 32'd0);
    if (abort_at >= 0) begin
      n = 0;
      while (!(sign2 && addra == 13'(abort_at)) && n < N_OUT + 5) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reached", {19'd0, addra}, abort_at);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("abort_sign", {31'd0, sign}, 32'd0);
      chk("abort_sign2", {31'd0, sign2}, 32'd0);
      chk("abort_addra", {19'd0, addra}, 32'd0);
      return;
    end
    @(negedge clk);
    n = 0;
    while (sign2 && n < N_OUT + 5) begin
      n++;
      @(negedge clk);
    end
    chk("sign2_run_length", n, N_OUT);
    chk("done_addra", {19'd0, addra}, N_OUT - 1);
    chk("done_res", {31'd0, res}, 32'd0);
    chk("done_sign", {31'd0, sign}, 32'd1);
    repeat (5) @(negedge clk);
    chk("done_hold_addra", {19'd0, addra}, N_OUT - 1);
    chk("done_hold_sign2", {31'd0, sign2}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (sign2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_sign2: got addra=%0d res=%0b expected no strobe", addra, res);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk("stream_addra_res", {18'd0, addra, res}, {18'd0, e});
      end
    end
  end

  // Test sequence and final report
  initial begin
    n_checks = 0;
    n_pass   = 0;
    set_image(0);
    reset_and_load(10);
    release_and_check(-1);

    set_image(1);
    reset_and_load(3);
    release_and_check(-1);

    set_image(2);
    reset_and_load(3);
    release_and_check(-1);

    set_image(3);
    reset_and_load(3);
    release_and_check(-1);

    set_image(4);
    reset_and_load(3);
    release_and_check(-1);

    set_image(4);
    reset_and_load(3);
    release_and_check(100);
    reset_and_load(0);
    release_and_check(-1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
